led_mode_sequencer: RTL and testbench
=====================================

# led_mode_sequencer

Sequencer and output stage directly downstream of the four LED pattern blocks in COMBINE4MODE, including MODE4_SANGDON. It divides the system clock into a step tick and runs each mode for a fixed number of steps. It issues a one-cycle restart pulse to each mode on entry, gates the active mode's enable with the tick, and registers the active mode's 8-bit pattern onto the board LEDs.

## Interface
- TICK_DIV, 4, clk cycles per step tick; legal range ≥ 2
- STEPS, 16, ticks per mode before auto-advance; legal range ≥ 1
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on rising clk; overrides all other inputs
- en  in  1  run/pause; 0 freezes sequencing
- skip  in  1  advance to next mode now; level-sampled, honoured only in RUN with en=1
- mode0_out, mode1_out, mode2_out, mode3_out  in  8 each  pattern outputs of the four mode blocks
- mode_en  out  4  one-hot; bit i is the step enable to mode block i
- mode_rst  out  4  one-hot; bit i is the active-high, one-cycle restart to mode block i
- mode_idx  out  2  currently selected mode
- OUT  out  8  registered LED pattern

## Operation
- States: IDLE, LOAD, RUN. State, mode_idx, prescaler (pre), step counter (step) and OUT are registers.
- Reset (reset=0 at an edge) sets:
  - state=IDLE, mode_idx=0, pre=0, step=0, OUT=8'h00.
  - mode_en and mode_rst are therefore 0.
- IDLE:
  - en=1 → LOAD.
  - en=0 → stay in IDLE.
- LOAD (exactly one cycle, independent of en and skip):
  - mode_rst[mode_idx]=1; all other mode_rst bits are 0.
  - pre and step are cleared to 0.
  - Next state is RUN.
- RUN with en=1:
  - pre counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (pre==TICK_DIV-1). mode_en[mode_idx]=tick; all other mode_en bits are 0.
  - On tick, step increments.
  - On tick with step==STEPS-1: mode_idx increments mod 4 (3 wraps to 0) → LOAD.
- RUN with en=0 (pause):
  - pre, step and mode_idx hold; tick=0 and mode_en=0.
  - OUT holds its last value.
  - State stays RUN; no restart pulse on resume.
- skip=1 in RUN with en=1:
  - mode_idx increments mod 4 → LOAD.
  - No mode_en pulse is issued that cycle.
  - skip coincident with the final tick produces a single advance, not two.
  - skip held high advances once per LOAD/RUN round trip, i.e. every 2 cycles.
- OUT:
  - In RUN it registers mode<mode_idx>_out every cycle that en=1.
  - In IDLE and LOAD it registers 8'h00.
- mode_en, mode_rst and tick are combinational decodes of the registered state, so there are no extra latency stages.
- reset=0 mid-RUN or mid-LOAD returns to IDLE at that edge. In the following cycles, mode_en and mode_rst are both 0.

## Timing
- With en=1 throughout, en sampled at edge k in IDLE gives:
  - LOAD during cycle k+1 (mode_rst visible).
  - RUN from cycle k+2.
  - First mode_en pulse in cycle k+1+TICK_DIV.
- mode_en pulses are one cycle wide and exactly TICK_DIV cycles apart while en=1.
- Dwell per mode with en steady high is 1 + STEPS·TICK_DIV cycles (LOAD plus run); the default is 65 cycles.
- OUT lags its selected mode input by one cycle. The first cycle of RUN after LOAD still shows 8'h00.
- Each pause cycle with en=0 in RUN extends the dwell by exactly one cycle.

## Test plan
Benches use TICK_DIV=2 and STEPS=3 unless stated.
- Reset then en=1 → LOAD one cycle with mode_rst=4'b0001, then mode_en=4'b0001 pulses every 2 cycles. After the 3rd pulse: mode_idx=1 and mode_rst=4'b0010 for one cycle. Dwell is 7 cycles.
- Free run for 28+ cycles → modes visit 0,1,2,3,0. The wrap 3→0 emits mode_rst=4'b0001. Drive mode_i_out=8'h11·(i+1) and check OUT follows with one-cycle lag and reads 8'h00 during each LOAD.
- Drop en for 5 cycles mid-RUN → mode_en=0, OUT, pre and step frozen; on resume the next pulse arrives at the remaining prescale count and the dwell grows by exactly 5.
- Pulse skip one cycle in RUN of mode 2 → mode_idx=3 and mode_rst=4'b1000 next cycle. Assert skip on the same cycle as the final tick → a single advance only.
- Assert reset=0 during LOAD and during RUN of mode 3 → next cycle: IDLE, mode_idx=0, OUT=8'h00, mode_en=mode_rst=0. Also check that reset wins over simultaneous en=1 and skip=1.
- Default parameters (4/16) → 65-cycle dwell, mode_en period 4 cycles; check for no glitch or double pulse across a 4-mode full cycle.

Source files
------------

// File: rtl/led_mode_sequencer.sv
// led_mode_sequencer
//   Steps through four LED pattern blocks. The system clock is divided into
//   a step tick, and each mode runs for STEPS ticks before the next mode is
//   selected. A mode gets a one-cycle restart pulse when it is entered. Its
//   step enable is gated by the tick. Its 8-bit pattern is registered onto
//   the board LEDs.
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-low reset
//   en         run/pause; 0 freezes sequencing
//   skip       advance to the next mode now (RUN with en=1 only)
//   modeN_out  pattern outputs of the four mode blocks
//   mode_en    one-hot step enable to the active mode block
//   mode_rst   one-hot, one-cycle restart to the mode being entered
//   mode_idx   currently selected mode
//   OUT        registered LED pattern
module led_mode_sequencer #(
  parameter int TICK_DIV = 4,
  parameter int STEPS    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       skip,
  input  logic [7:0] mode0_out,
  input  logic [7:0] mode1_out,
  input  logic [7:0] mode2_out,
  input  logic [7:0] mode3_out,
  output logic [3:0] mode_en,
  output logic [3:0] mode_rst,
  output logic [1:0] mode_idx,
  output logic [7:0] OUT
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (STEPS > 1) ? $clog2(STEPS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t        state;
  logic [PW-1:0] pre;
  logic [SW-1:0] step;

  logic [7:0] sel;
  logic [3:0] onehot;
  logic       run_en, tick, last, advance;

  always_comb begin
    sel = mode0_out;
    case (mode_idx)
      2'd0: sel = mode0_out;
      2'd1: sel = mode1_out;
      2'd2: sel = mode2_out;
      2'd3: sel = mode3_out;
      default: sel = mode0_out;
    endcase
  end

  assign onehot  = 4'b0001 << mode_idx;
  assign run_en  = (state == RUN) && en;
  assign tick    = run_en && (pre == PW'(TICK_DIV - 1));
  assign last    = (step == SW'(STEPS - 1));
  // A skip that lands on the final tick still advances only once.
  assign advance = run_en && (skip || (tick && last));

  // The enable pulse is suppressed on a skip cycle. The mode is being left,
  // so it must not take a step.
  assign mode_en  = (tick && !skip) ? onehot : 4'b0000;
  assign mode_rst = (state == LOAD) ? onehot : 4'b0000;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      mode_idx <= 2'd0;
      pre      <= '0;
      step     <= '0;
      OUT      <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          OUT <= 8'h00;
          if (en) state <= LOAD;
        end
        LOAD: begin
          OUT   <= 8'h00;
          pre   <= '0;
          step  <= '0;
          state <= RUN;
        end
        RUN: begin
          // With en=0, every register holds. This pauses the dwell.
          if (en) begin
            OUT <= sel;
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) step <= step + 1'b1;
            if (advance) begin
              mode_idx <= mode_idx + 2'd1;
              state    <= LOAD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// tb_led_mode_sequencer
//   Two instances share the same inputs. The first uses TICK_DIV=2, STEPS=3.
//   The second uses the defaults 4/16. Each instance is compared every cycle
//   against a reference model. The model tracks the phase, the mode, and the
//   number of enabled RUN cycles since the mode was entered. Directed
//   sequences cover dwell, pause, skip and reset cases. Randomized traffic
//   follows them.
module tb_led_mode_sequencer;

  logic       clk = 1'b0;
  logic       reset, en, skip;
  logic [7:0] mo [4];
  logic [3:0] d_en  [2];
  logic [3:0] d_rst [2];
  logic [1:0] d_idx [2];
  logic [7:0] d_out [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  led_mode_sequencer #(.TICK_DIV(2), .STEPS(3)) u_a (
    .clk(clk), .reset(reset), .en(en), .skip(skip),
    .mode0_out(mo[0]), .mode1_out(mo[1]), .mode2_out(mo[2]), .mode3_out(mo[3]),
    .mode_en(d_en[0]), .mode_rst(d_rst[0]), .mode_idx(d_idx[0]), .OUT(d_out[0]));

  led_mode_sequencer u_b (
    .clk(clk), .reset(reset), .en(en), .skip(skip),
    .mode0_out(mo[0]), .mode1_out(mo[1]), .mode2_out(mo[2]), .mode3_out(mo[3]),
    .mode_en(d_en[1]), .mode_rst(d_rst[1]), .mode_idx(d_idx[1]), .OUT(d_out[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // phase: 0 idle, 1 load, 2 run. cnt = enabled RUN cycles elapsed in this mode.
  int         td [2] = '{2, 4};
  int         st [2] = '{3, 16};
  int         m_phase [2] = '{0, 0};
  int         m_mode  [2] = '{0, 0};
  int         m_cnt   [2] = '{0, 0};
  logic [7:0] m_out   [2] = '{8'h00, 8'h00};

  function automatic logic [3:0] exp_en(int i);
    if (m_phase[i] == 2 && en && !skip && ((m_cnt[i] + 1) % td[i] == 0))
      return 4'(1 << m_mode[i]);
    return 4'b0000;
  endfunction

  function automatic logic [3:0] exp_rst(int i);
    return (m_phase[i] == 1) ? 4'(1 << m_mode[i]) : 4'b0000;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        m_phase[i] <= 0; m_mode[i] <= 0; m_cnt[i] <= 0; m_out[i] <= 8'h00;
      end else if (m_phase[i] == 0) begin
        m_out[i] <= 8'h00;
        if (en) m_phase[i] <= 1;
      end else if (m_phase[i] == 1) begin
        m_out[i] <= 8'h00; m_cnt[i] <= 0; m_phase[i] <= 2;
      end else if (en) begin
        m_out[i] <= mo[m_mode[i]];
        if (skip || (m_cnt[i] + 1 == st[i] * td[i])) begin
          m_mode[i] <= (m_mode[i] + 1) % 4;
          m_phase[i] <= 1;
        end else begin
          m_cnt[i] <= m_cnt[i] + 1;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic chk_on = 1'b0;
  logic rec    = 1'b0;
  int   cyc    = 0;
  int   qa[$];
  int   qb[$];

  always @(negedge clk) begin
    cyc++;
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("mode_en[%0d]", i),  d_en[i],  exp_en(i));
        chk($sformatf("mode_rst[%0d]", i), d_rst[i], exp_rst(i));
        chk($sformatf("mode_idx[%0d]", i), d_idx[i], m_mode[i]);
        chk($sformatf("OUT[%0d]", i),      d_out[i], m_out[i]);
      end
    end
    if (rec && d_rst[0] != 4'b0) qa.push_back(cyc);
    if (rec && d_rst[1] != 4'b0) qb.push_back(cyc);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic r, input logic e, input logic s);
    reset = r; en = e; skip = s;
    for (int j = 0; j < 4; j++) mo[j] = 8'($urandom);
    @(posedge clk); #1;
  endtask

  initial begin
    int  n;
    bit  hit;
    reset = 1'b0; en = 1'b0; skip = 1'b0;
    for (int j = 0; j < 4; j++) mo[j] = 8'h11 * 8'(j + 1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    chk("rst_idx", d_idx[0], 0);
    chk("rst_out", d_out[0], 8'h00);
    chk("rst_en",  d_en[0],  4'b0000);
    chk("rst_rst", d_rst[0], 4'b0000);
    chk_on = 1'b1;

    // Steady run: dwell is 7 cycles for 2/3 and 65 cycles for the defaults.
    drive(1'b1, 1'b0, 1'b0);
    rec = 1'b1;
    for (int k = 0; k < 300; k++) drive(1'b1, 1'b1, 1'b0);
    rec = 1'b0;
    chk("dwellA_count", 32'(qa.size() >= 10), 1);
    chk("dwellB_count", 32'(qb.size() >= 4), 1);
    for (int k = 1; k < qa.size(); k++) chk("dwellA", qa[k] - qa[k-1], 7);
    for (int k = 1; k < qb.size(); k++) chk("dwellB", qb[k] - qb[k-1], 65);

    // Pause for 5 cycles mid-RUN.
    drive(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b1, 1'b0);

    // Skip a single cycle in RUN of mode 2 on instance A.
    hit = 0;
    for (n = 0; n < 40; n++) begin
      if (d_idx[0] == 2'd2 && d_rst[0] == 4'b0) begin hit = 1; break; end
      drive(1'b1, 1'b1, 1'b0);
    end
    chk("wait_mode2", 32'(hit), 1);
    drive(1'b1, 1'b1, 1'b1);
    chk("skip_idx", d_idx[0], 2'd3);
    chk("skip_rst", d_rst[0], 4'b1000);
    for (int k = 0; k < 10; k++) drive(1'b1, 1'b1, 1'b0);

    // Reset during LOAD, with en and skip also asserted.
    hit = 0;
    for (n = 0; n < 40; n++) begin
      if (d_rst[0] != 4'b0) begin hit = 1; break; end
      drive(1'b1, 1'b1, 1'b0);
    end
    chk("wait_load", 32'(hit), 1);
    drive(1'b0, 1'b1, 1'b1);
    chk("rstL_idx", d_idx[0], 0);
    chk("rstL_out", d_out[0], 8'h00);
    chk("rstL_rst", d_rst[0], 4'b0000);
    chk("rstL_en",  d_en[0],  4'b0000);

    // Reset during RUN of mode 3.
    hit = 0;
    for (n = 0; n < 60; n++) begin
      if (d_idx[0] == 2'd3 && d_rst[0] == 4'b0) begin hit = 1; break; end
      drive(1'b1, 1'b1, 1'b0);
    end
    chk("wait_mode3", 32'(hit), 1);
    drive(1'b0, 1'b1, 1'b1);
    chk("rstR_idx", d_idx[0], 0);
    chk("rstR_out", d_out[0], 8'h00);
    chk("rstR_rst", d_rst[0], 4'b0000);
    chk("rstR_en",  d_en[0],  4'b0000);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++)
      drive(($urandom_range(39) != 0), ($urandom_range(99) < 85), ($urandom_range(99) < 8));

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
